d_forward_hazard_unit: RTL and testbench

// Decode-stage hazard and forwarding unit for the 5-stage MIPS pipeline. Tracks in-flight

---
 rtl/d_forward_hazard_unit_pkg.sv | 43 ++++
 rtl/d_forward_hazard_unit_if.sv | 47 ++++
 rtl/d_forward_hazard_unit_fwd_port_select.sv | 73 +++++++
 rtl/d_forward_hazard_unit.sv | 88 ++++++++
 tb/tb_d_forward_hazard_unit.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/d_forward_hazard_unit_pkg.sv
// ----------------------------------------------------------------------------
// d_forward_hazard_unit_pkg
// Shared definitions for the decode-stage hazard/forwarding unit:
//   - producer stage indices (E, M, W) as seen from D
//   - fwd_sel encodings (rf / W / M / E)
//   - hazard record layout {vld, wa, tnew} and its field widths
//   - helpers: Tnew countdown step, stage-index to fwd_sel mapping
// No ports (package).
// ----------------------------------------------------------------------------
package d_forward_hazard_unit_pkg;

   localparam int STG_E = 0;
   localparam int STG_M = 1;
   localparam int STG_W = 2;

   // Record field widths; the top-level AW/TW parameters must equal these.
   localparam int REC_AW = 5;
   localparam int REC_TW = 2;

   typedef enum logic [1:0] {
      SEL_RF = 2'd0,
      SEL_W  = 2'd1,
      SEL_M  = 2'd2,
      SEL_E  = 2'd3
   } fwd_sel_e;

   typedef struct packed {
      logic              vld;
      logic [REC_AW-1:0] wa;
      logic [REC_TW-1:0] tnew;
   } hz_rec_t;

   // Tnew saturates at zero once the result exists in the pipeline.
   function automatic logic [REC_TW-1:0] tnew_step(input logic [REC_TW-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

   // Stage k (0 = E) maps to selector 3-k, so E=3, M=2, W=1.
   function automatic fwd_sel_e stage_sel(input int k);
      return fwd_sel_e'(2'(int'(SEL_E) - k));
   endfunction

endpackage

// File: rtl/d_forward_hazard_unit_if.sv
// ----------------------------------------------------------------------------
// d_forward_hazard_unit_if
// Bundles the D-stage request, producer result buses and resolved operands
// of the hazard/forwarding unit.
//   master : drives the D-stage instruction fields, rf/stage data, and
//            receives fwd_data / fwd_sel / stall
//   slave  : the hazard unit itself
// Signals:
//   d_valid, d_wen, d_wa, d_tnew, d_is_md, mdu_busy, flush  D-stage control
//   d_ra[NRP*AW], d_tuse[NRP*TW], rf_rd[NRP*DW]             read ports
//   stage_data[NSTAGE*DW]                                   E/M/W results
//   fwd_data[NRP*DW], fwd_sel[NRP*2], stall                 outputs
// ----------------------------------------------------------------------------
interface d_forward_hazard_unit_if #(
   parameter int DW     = 32,
   parameter int AW     = 5,
   parameter int NRP    = 2,
   parameter int NSTAGE = 3,
   parameter int TW     = 2
);
   logic                  d_valid;
   logic                  d_wen;
   logic [AW-1:0]         d_wa;
   logic [TW-1:0]         d_tnew;
   logic                  d_is_md;
   logic                  mdu_busy;
   logic                  flush;
   logic [NRP*AW-1:0]     d_ra;
   logic [NRP*TW-1:0]     d_tuse;
   logic [NRP*DW-1:0]     rf_rd;
   logic [NSTAGE*DW-1:0]  stage_data;
   logic [NRP*DW-1:0]     fwd_data;
   logic [NRP*2-1:0]      fwd_sel;
   logic                  stall;

   modport master (
      output d_valid, d_wen, d_wa, d_tnew, d_is_md, mdu_busy, flush,
             d_ra, d_tuse, rf_rd, stage_data,
      input  fwd_data, fwd_sel, stall
   );

   modport slave (
      input  d_valid, d_wen, d_wa, d_tnew, d_is_md, mdu_busy, flush,
             d_ra, d_tuse, rf_rd, stage_data,
      output fwd_data, fwd_sel, stall
   );
endinterface

// File: rtl/d_forward_hazard_unit_fwd_port_select.sv
// ----------------------------------------------------------------------------
// fwd_port_select
// One D-stage read port: finds the youngest in-flight producer of the port's
// register, then either forwards its stage result, falls back to the
// register file, or flags a hazard when the value cannot arrive in time.
// Purely combinational.
// Ports:
//   i_rec        in  NSTAGE records, index 0 = E (youngest)
//   i_ra         in  read address (0 never matches)
//   i_tuse       in  cycles until this operand is consumed
//   i_rf_rd      in  register-file read data
//   i_stage_data in  result bus per stage, stage k = bits [k*DW +: DW]
//   o_data       out resolved operand
//   o_sel        out source selector (rf/W/M/E)
//   o_hazard     out producer result not ready in time
// ----------------------------------------------------------------------------
module fwd_port_select
   import d_forward_hazard_unit_pkg::*;
#(
   parameter int DW     = 32,
   parameter int AW     = 5,
   parameter int TW     = 2,
   parameter int NSTAGE = 3
) (
   input  hz_rec_t [NSTAGE-1:0]   i_rec,
   input  logic [AW-1:0]          i_ra,
   input  logic [TW-1:0]          i_tuse,
   input  logic [DW-1:0]          i_rf_rd,
   input  logic [NSTAGE*DW-1:0]   i_stage_data,
   output logic [DW-1:0]          o_data,
   output logic [1:0]             o_sel,
   output logic                   o_hazard
);

   logic                w_ra_nz;
   logic [NSTAGE-1:0]   w_match;

   assign w_ra_nz = (i_ra != '0);

   genvar gi;
   generate
      for (gi = 0; gi < NSTAGE; gi++) begin : g_match
         assign w_match[gi] = i_rec[gi].vld & (i_rec[gi].wa == i_ra) & w_ra_nz;
      end
   endgenerate

   // Walk from oldest to youngest so the youngest matching producer is the
   // last one to write the outputs.
   always_comb begin
      o_data   = i_rf_rd;
      o_sel    = SEL_RF;
      o_hazard = 1'b0;
      for (int k = NSTAGE - 1; k >= 0; k--) begin
         if (w_match[k]) begin
            if (i_rec[k].tnew > i_tuse) begin
               o_hazard = 1'b1;
               o_data   = i_rf_rd;
               o_sel    = SEL_RF;
            end else if (i_rec[k].tnew == '0) begin
               o_hazard = 1'b0;
               o_data   = i_stage_data[k*DW +: DW];
               o_sel    = stage_sel(k);
            end else begin
               // Ready before use but not yet: later-stage forwarders take it.
               o_hazard = 1'b0;
               o_data   = i_rf_rd;
               o_sel    = SEL_RF;
            end
         end
      end
   end

endmodule

// File: rtl/d_forward_hazard_unit.sv
// ----------------------------------------------------------------------------
// d_forward_hazard_unit
// Decode-stage hazard detection and operand forwarding for the 5-stage MIPS
// pipeline. Keeps one {vld, wa, tnew} record per stage E/M/W, counts Tnew down
// as records age, resolves NRP read ports and raises stall when an operand
// cannot be ready in time or the MDU is busy for an MDU instruction.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-high, clears every record
//   bus    slave modport of d_forward_hazard_unit_if (D-stage fields, rf and
//          stage data in; fwd_data, fwd_sel, stall out)
// ----------------------------------------------------------------------------
module d_forward_hazard_unit
   import d_forward_hazard_unit_pkg::*;
#(
   parameter int DW     = 32,
   parameter int AW     = REC_AW,
   parameter int NRP    = 2,
   parameter int NSTAGE = 3,
   parameter int TW     = REC_TW
) (
   input  logic                      clk,
   input  logic                      reset,
   d_forward_hazard_unit_if.slave    bus
);

   hz_rec_t [NSTAGE-1:0]   r_rec;
   hz_rec_t                w_rec0;
   logic [NRP-1:0]         w_hazard;
   logic [NRP*DW-1:0]      w_fwd_data;
   logic [NRP*2-1:0]       w_fwd_sel;
   logic                   w_md_stall;
   logic                   w_stall;

   // Record entering E; a stall or flush turns it into a bubble.
   always_comb begin
      w_rec0      = '0;
      w_rec0.vld  = bus.d_valid & bus.d_wen & (bus.d_wa != '0) & ~w_stall & ~bus.flush;
      w_rec0.wa   = bus.d_wa;
      w_rec0.tnew = bus.d_tnew;
   end

   // Stages after E always advance; stall only affects what enters E.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rec <= '0;
      end else begin
         r_rec[0] <= w_rec0;
         for (int k = 1; k < NSTAGE; k++) begin
            r_rec[k].vld  <= r_rec[k-1].vld;
            r_rec[k].wa   <= r_rec[k-1].wa;
            r_rec[k].tnew <= tnew_step(r_rec[k-1].tnew);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NRP; gi++) begin : g_port
         fwd_port_select #(
            .DW     (DW),
            .AW     (AW),
            .TW     (TW),
            .NSTAGE (NSTAGE)
         ) u_port (
            .i_rec        (r_rec),
            .i_ra         (bus.d_ra[gi*AW +: AW]),
            .i_tuse       (bus.d_tuse[gi*TW +: TW]),
            .i_rf_rd      (bus.rf_rd[gi*DW +: DW]),
            .i_stage_data (bus.stage_data),
            .o_data       (w_fwd_data[gi*DW +: DW]),
            .o_sel        (w_fwd_sel[gi*2 +: 2]),
            .o_hazard     (w_hazard[gi])
         );
      end
   endgenerate

   assign w_md_stall = bus.d_is_md & bus.mdu_busy;

   // Reset gates stall directly so it drops in the same cycle reset rises,
   // including the MDU term which does not depend on the records.
   assign w_stall = ~reset & bus.d_valid & ((|w_hazard) | w_md_stall);

   assign bus.fwd_data = w_fwd_data;
   assign bus.fwd_sel  = w_fwd_sel;
   assign bus.stall    = w_stall;

endmodule

// File: tb/tb_d_forward_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_d_forward_hazard_unit
// Directed scenarios with literal expectations, then randomized traffic.
// A reference model tracks each in-flight write by its age since entering E
// and derives the remaining Tnew as max(tnew_at_entry - age, 0).
// ----------------------------------------------------------------------------
module tb_d_forward_hazard_unit;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NRP = 2;
   localparam int NS = 3;
   localparam int TW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              v, wen, md, busy, fl;
   logic [AW-1:0]     wa;
   logic [TW-1:0]     tnew;
   logic [AW-1:0]     ra   [NRP];
   logic [TW-1:0]     tuse [NRP];
   logic [DW-1:0]     rf   [NRP];
   logic [DW-1:0]     sd   [NS];

   int n_tests = 0;
   int n_fail  = 0;

   d_forward_hazard_unit_if #(.DW(DW), .AW(AW), .NRP(NRP), .NSTAGE(NS), .TW(TW)) u_if ();

   assign u_if.d_valid    = v;
   assign u_if.d_wen      = wen;
   assign u_if.d_wa       = wa;
   assign u_if.d_tnew     = tnew;
   assign u_if.d_is_md    = md;
   assign u_if.mdu_busy   = busy;
   assign u_if.flush      = fl;
   assign u_if.d_ra       = {ra[1], ra[0]};
   assign u_if.d_tuse     = {tuse[1], tuse[0]};
   assign u_if.rf_rd      = {rf[1], rf[0]};
   assign u_if.stage_data = {sd[2], sd[1], sd[0]};

   d_forward_hazard_unit #(.DW(DW), .AW(AW), .NRP(NRP), .NSTAGE(NS), .TW(TW)) u_dut (
      .clk   (clk),
      .reset (rst),
      .bus   (u_if)
   );

   // ---------------- reference model: writes indexed by age ----------------
   int m_vld [NS];
   int m_wa  [NS];
   int m_t0  [NS];

   function automatic void eval_port(input int p, output bit hz,
                                     output logic [1:0] sel, output logic [DW-1:0] data);
      int rem;
      hz = 0; sel = 2'd0; data = rf[p];
      if (ra[p] != 0) begin
         for (int age = 0; age < NS; age++) begin
            if (m_vld[age] != 0 && m_wa[age] == int'(ra[p])) begin
               rem = (m_t0[age] > age) ? m_t0[age] - age : 0;
               if (rem > int'(tuse[p])) hz = 1;
               else if (rem == 0) begin
                  sel  = 2'(3 - age);
                  data = sd[age];
               end
               break;
            end
         end
      end
   endfunction

   function automatic bit model_stall();
      bit hz, any;
      logic [1:0] s;
      logic [DW-1:0] d;
      any = 0;
      for (int p = 0; p < NRP; p++) begin
         eval_port(p, hz, s, d);
         any |= hz;
      end
      return !rst && v && (any || (md && busy));
   endfunction

   always @(posedge clk) begin
      bit s;
      assert (!(v && wen && int'(tnew) > NS - 1))
         else $error("illegal d_tnew %0d", tnew);
      if (rst) begin
         for (int a = 0; a < NS; a++) begin m_vld[a] = 0; m_wa[a] = 0; m_t0[a] = 0; end
      end else begin
         s = model_stall();
         for (int a = NS - 1; a > 0; a--) begin
            m_vld[a] = m_vld[a-1]; m_wa[a] = m_wa[a-1]; m_t0[a] = m_t0[a-1];
         end
         m_vld[0] = (v && wen && wa != 0 && !s && !fl) ? 1 : 0;
         m_wa[0]  = int'(wa);
         m_t0[0]  = int'(tnew);
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      bit hz;
      logic [1:0] s;
      logic [DW-1:0] d;
      chk("cyc_stall", DW'(u_if.stall), DW'(model_stall()));
      for (int p = 0; p < NRP; p++) begin
         if (rst) begin
            hz = 0; s = 2'd0; d = rf[p];
         end else begin
            eval_port(p, hz, s, d);
         end
         if (!hz) begin
            chk($sformatf("cyc_sel%0d", p), DW'(u_if.fwd_sel[p*2 +: 2]), DW'(s));
            chk($sformatf("cyc_data%0d", p), u_if.fwd_data[p*DW +: DW], d);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      v = 0; wen = 0; wa = '0; tnew = '0; md = 0; busy = 0; fl = 0;
      for (int p = 0; p < NRP; p++) begin ra[p] = '0; tuse[p] = '0; end
   endtask

   task automatic note(input string name);
      $display("[TB] directed %s checked", name);
   endtask

   initial begin
      rst = 1;
      idle();
      rf[0] = 32'h0000_0055; rf[1] = 32'h0000_0066;
      sd[0] = 32'h0000_AAAA; sd[1] = 32'h0000_BBBB; sd[2] = 32'h0000_1234;

      // 1: reset held with a live reader
      v = 1; ra[0] = 5'd5;
      #2;
      chk("rst_stall", DW'(u_if.stall), 0);
      chk("rst_sel0", DW'(u_if.fwd_sel[1:0]), 0);
      chk("rst_data0", u_if.fwd_data[31:0], 32'h55);
      note("reset");
      tick(); rst = 0;
      #2;
      chk("post_rst_sel0", DW'(u_if.fwd_sel[1:0]), 0);
      note("post_reset");

      // 2: lw $8 (tnew=2) then beq $8 (tuse=0): two stalls, then W forwards
      tick(); idle(); v = 1; wen = 1; wa = 5'd8; tnew = 2'd2;
      tick(); wen = 0; wa = '0; tnew = '0; ra[0] = 5'd8; tuse[0] = 2'd0;
      #2; chk("lw_stall1", DW'(u_if.stall), 1);
      tick(); #2; chk("lw_stall2", DW'(u_if.stall), 1);
      tick(); #2;
      chk("lw_nostall", DW'(u_if.stall), 0);
      chk("lw_sel0", DW'(u_if.fwd_sel[1:0]), 1);
      chk("lw_data0", u_if.fwd_data[31:0], 32'h1234);
      note("load_use");

      // 3: addu $9 (tnew=1), addu $10,$9,$9 (tuse=1), then beq $9
      tick(); idle(); v = 1; wen = 1; wa = 5'd9; tnew = 2'd1;
      tick(); wa = 5'd10; tnew = 2'd1; ra[0] = 5'd9; ra[1] = 5'd9; tuse[0] = 2'd1; tuse[1] = 2'd1;
      #2;
      chk("alu_stall", DW'(u_if.stall), 0);
      chk("alu_sel0", DW'(u_if.fwd_sel[1:0]), 0);
      chk("alu_sel1", DW'(u_if.fwd_sel[3:2]), 0);
      chk("alu_data0", u_if.fwd_data[31:0], 32'h55);
      tick(); wen = 0; wa = '0; tnew = '0; ra[0] = 5'd9; ra[1] = '0; tuse[0] = 2'd0;
      #2;
      chk("beq_stall", DW'(u_if.stall), 0);
      chk("beq_sel0", DW'(u_if.fwd_sel[1:0]), 2);
      chk("beq_data0", u_if.fwd_data[31:0], 32'hBBBB);
      note("alu_chain");

      // 4: $4 produced in M and again in E; youngest (E) wins on both ports
      tick(); idle(); v = 1; wen = 1; wa = 5'd4; tnew = 2'd0;
      tick();
      tick(); wen = 0; wa = '0; ra[0] = 5'd4; ra[1] = 5'd4;
      #2;
      chk("yng_sel0", DW'(u_if.fwd_sel[1:0]), 3);
      chk("yng_sel1", DW'(u_if.fwd_sel[3:2]), 3);
      chk("yng_data0", u_if.fwd_data[31:0], 32'hAAAA);
      chk("yng_data1", u_if.fwd_data[63:32], 32'hAAAA);
      note("youngest");

      // 5: write to $0 is never tracked
      tick(); idle(); v = 1; wen = 1; wa = '0; tnew = 2'd0;
      tick(); wen = 0; ra[0] = '0;
      #2;
      chk("zero_sel0", DW'(u_if.fwd_sel[1:0]), 0);
      chk("zero_stall", DW'(u_if.stall), 0);
      chk("zero_data0", u_if.fwd_data[31:0], 32'h55);
      note("reg_zero");

      // 6: MDU busy for 5 cycles holds stall
      tick(); idle(); v = 1; md = 1; busy = 1;
      for (int i = 0; i < 5; i++) begin
         #2; chk($sformatf("md_stall%0d", i), DW'(u_if.stall), 1);
         tick();
      end
      busy = 0;
      #2; chk("md_release", DW'(u_if.stall), 0);
      note("mdu_busy");

      // flush together with stall: one bubble, no record for $7
      tick(); v = 1; wen = 1; wa = 5'd7; tnew = 2'd0; md = 1; busy = 1; fl = 1;
      #2; chk("fl_stall", DW'(u_if.stall), 1);
      tick(); idle(); v = 1; ra[0] = 5'd7;
      #2;
      chk("fl_sel0", DW'(u_if.fwd_sel[1:0]), 0);
      chk("fl_stall_after", DW'(u_if.stall), 0);
      note("flush_stall");

      // reset rising mid-stall drops stall immediately
      tick(); idle(); v = 1; wen = 1; wa = 5'd8; tnew = 2'd2;
      tick(); wen = 0; wa = '0; tnew = '0; ra[0] = 5'd8;
      #2; chk("mid_stall", DW'(u_if.stall), 1);
      rst = 1;
      #1; chk("mid_rst_stall", DW'(u_if.stall), 0);
      tick(); rst = 0;
      #2; chk("mid_rst_clear", DW'(u_if.stall), 0);
      note("reset_mid_stall");

      // randomized traffic, checked each cycle by the compare process
      for (int c = 0; c < 3000; c++) begin
         tick();
         rst  = ($urandom_range(0, 199) == 0);
         v    = ($urandom_range(0, 3) != 0);
         wen  = $urandom_range(0, 1) == 1;
         wa   = AW'($urandom_range(0, 7));
         tnew = TW'($urandom_range(0, 2));
         md   = ($urandom_range(0, 3) == 0);
         busy = ($urandom_range(0, 2) == 0);
         fl   = ($urandom_range(0, 7) == 0);
         for (int p = 0; p < NRP; p++) begin
            ra[p]   = AW'($urandom_range(0, 7));
            tuse[p] = TW'($urandom_range(0, 3));
            rf[p]   = $urandom;
         end
         for (int k = 0; k < NS; k++) sd[k] = $urandom;
      end

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
